// File: rtl/register_file_nr_1w_be_ff.sv
// Flip-flop register file: N_READ registered-address read ports, one byte-enabled
// write port, and a sequencer that sweeps every word to a programmable value.
module register_file_nr_1w_be_ff #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_READ     = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_READ-1:0]            ReadEnable,
  input  logic [N_READ*ADDR_WIDTH-1:0] ReadAddr,
  output logic [N_READ*DATA_WIDTH-1:0] ReadData,
  input  logic                         WriteEnable,
  input  logic [ADDR_WIDTH-1:0]        WriteAddr,
  input  logic [DATA_WIDTH-1:0]        WriteData,
  input  logic [DATA_WIDTH/8-1:0]      WriteBE,
  input  logic                         InitReq,
  input  logic [DATA_WIDTH-1:0]        InitData,
  output logic                         InitBusy
);

  localparam int unsigned NUM_WORDS = 2**ADDR_WIDTH;
  localparam int unsigned NB        = DATA_WIDTH/8;

  typedef enum logic {IDLE, INIT} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   init_data_q, init_data_d;
  logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];
  logic [ADDR_WIDTH-1:0]   raddr_q [N_READ];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NB-1:0]           wr_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      init_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_data_q <= init_data_d;
    end
  end

  // The sweep owns the write port while busy, so external writes simply drop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_data_d = init_data_q;
    wr_en       = WriteEnable;
    wr_addr     = WriteAddr;
    wr_data     = WriteData;
    wr_be       = WriteBE;
    unique case (state_q)
      IDLE: begin
        if (InitReq) begin
          state_d     = INIT;
          cnt_d       = '0;
          init_data_d = InitData;
        end
      end
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = init_data_q;
        wr_be   = '1;
        if (&cnt_q) state_d = IDLE;
        else        cnt_d   = cnt_q + ADDR_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign InitBusy = (state_q == INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned w = 0; w < NUM_WORDS; w++) mem_q[w] <= '0;
    end else if (wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < N_READ; p++) raddr_q[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < N_READ; p++) begin
        if (ReadEnable[p]) raddr_q[p] <= ReadAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    assign ReadData[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_q[p]];
  end

endmodule

// File: tb/tb_register_file_nr_1w_be_ff.sv
// Bench for register_file_nr_1w_be_ff: directed scenarios plus random traffic,
// all compared against an array-based reference of the storage and read pointers.
module tb_register_file_nr_1w_be_ff;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NW = 32;
  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   ReadEnable;
  logic [NR*AW-1:0] ReadAddr;
  logic [NR*DW-1:0] ReadData;
  logic            WriteEnable;
  logic [AW-1:0]   WriteAddr;
  logic [DW-1:0]   WriteData;
  logic [NB-1:0]   WriteBE;
  logic            InitReq;
  logic [DW-1:0]   InitData;
  logic            InitBusy;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ref_mem [NW];
  logic [AW-1:0] ref_raddr [NR];
  bit            ref_busy;
  int            ref_pos;
  logic [DW-1:0] ref_init_val;

  register_file_nr_1w_be_ff #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .N_READ    (NR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ReadEnable (ReadEnable),
    .ReadAddr   (ReadAddr),
    .ReadData   (ReadData),
    .WriteEnable(WriteEnable),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .WriteBE    (WriteBE),
    .InitReq    (InitReq),
    .InitData   (InitData),
    .InitBusy   (InitBusy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int p = 0; p < NR; p++)
      check($sformatf("%s rd%0d", tag, p), ReadData[p*DW +: DW], ref_mem[ref_raddr[p]]);
    check({tag, " busy"}, {31'b0, InitBusy}, {31'b0, ref_busy});
  endtask

  // What one clock edge does to the storage, per the behavioural rules.
  task automatic ref_edge();
    if (ref_busy) begin
      ref_mem[ref_pos] = ref_init_val;
      ref_pos++;
      if (ref_pos == NW) ref_busy = 1'b0;
    end else begin
      if (WriteEnable)
        for (int b = 0; b < NB; b++)
          if (WriteBE[b]) ref_mem[WriteAddr][8*b +: 8] = WriteData[8*b +: 8];
      if (InitReq) begin
        ref_busy     = 1'b1;
        ref_pos      = 0;
        ref_init_val = InitData;
      end
    end
    for (int p = 0; p < NR; p++)
      if (ReadEnable[p]) ref_raddr[p] = ReadAddr[p*AW +: AW];
  endtask

  task automatic tick(input string tag);
    ref_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    ReadEnable  = '0;
    WriteEnable = 1'b0;
    WriteAddr   = '0;
    WriteData   = '0;
    WriteBE     = '0;
    InitReq     = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    ReadEnable[p]       = 1'b1;
    ReadAddr[p*AW +: AW] = a;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    for (int w = 0; w < NW; w++) ref_mem[w] = '0;
    for (int p = 0; p < NR; p++) ref_raddr[p] = '0;
    ref_busy = 1'b0;
    ref_pos  = 0;
    #2;
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int busy_cycles;
    idle_inputs();
    ReadAddr = '0;
    InitData = '0;
    ref_init_val = '0;
    #3;
    do_reset("por");

    // Reset contents seen through every port
    set_rd(0, 5'd0); set_rd(1, 5'd5); set_rd(2, 5'd31);
    tick("rd_reset");
    idle_inputs();

    // Byte enables
    WriteEnable = 1'b1; WriteAddr = 5'd3; WriteData = 32'hAABBCCDD; WriteBE = 4'hF;
    tick("be_full");
    WriteData = 32'h11223344; WriteBE = 4'h5;
    tick("be_part");
    WriteData = 32'hFFFFFFFF; WriteBE = 4'h0;
    set_rd(0, 5'd3);
    tick("be_zero");
    check("be_const", ReadData[31:0], 32'hAA22CC44);
    idle_inputs();

    // Multi-port visibility
    set_rd(0, 5'd7); set_rd(1, 5'd8);
    tick("hold78");
    idle_inputs();
    WriteEnable = 1'b1; WriteAddr = 5'd7; WriteData = 32'h12345678; WriteBE = 4'hF;
    tick("wr7");
    check("wr7_const", ReadData[31:0], 32'h12345678);
    idle_inputs();

    // Address capture and write to the same word on one edge
    WriteEnable = 1'b1; WriteAddr = 5'd9; WriteData = 32'hCAFEF00D; WriteBE = 4'hF;
    set_rd(2, 5'd9);
    tick("same_cycle");
    check("same_cycle_const", ReadData[95:64], 32'hCAFEF00D);
    idle_inputs();

    // Random traffic, with the occasional sweep
    for (int i = 0; i < 400; i++) begin
      ReadEnable  = NR'($urandom);
      ReadAddr    = (NR*AW)'($urandom);
      WriteEnable = 1'($urandom);
      WriteAddr   = AW'($urandom);
      WriteData   = $urandom;
      WriteBE     = NB'($urandom);
      InitReq     = ($urandom_range(0, 59) == 0);
      InitData    = $urandom;
      tick("rand");
    end
    idle_inputs();
    repeat (NW + 1) tick("drain");

    // Full sweep with InitReq held and writes hammering during it
    InitReq = 1'b1; InitData = 32'hDEADBEEF;
    tick("init_start");
    busy_cycles = 0;
    for (int i = 0; i < NW + 8 && InitBusy; i++) begin
      busy_cycles++;
      WriteEnable = 1'b1; WriteAddr = AW'($urandom); WriteData = $urandom; WriteBE = 4'hF;
      ReadEnable = NR'($urandom); ReadAddr = (NR*AW)'($urandom);
      tick("sweep");
    end
    check("busy_len", 32'(busy_cycles), 32'd32);
    idle_inputs();
    for (int w = 0; w < NW; w++) begin
      set_rd(0, AW'(w)); set_rd(1, AW'(NW - 1 - w));
      tick("readback");
      check("readback_const", ReadData[31:0], 32'hDEADBEEF);
    end
    idle_inputs();

    // Write and InitReq on the same idle edge
    WriteEnable = 1'b1; WriteAddr = 5'd0; WriteData = 32'h00000001; WriteBE = 4'hF;
    InitReq = 1'b1; InitData = 32'h5A5A1234;
    set_rd(0, 5'd0);
    tick("wr_and_init");
    idle_inputs();
    repeat (NW) tick("wi_sweep");
    check("wi_const", ReadData[31:0], 32'h5A5A1234);

    // Reset at cnt = 10
    InitReq = 1'b1; InitData = 32'h0BADC0DE;
    tick("mid_start");
    idle_inputs();
    repeat (10) tick("mid_sweep");
    do_reset("mid_reset");
    set_rd(0, 5'd0); set_rd(1, 5'd5); set_rd(2, 5'd9);
    tick("after_reset");
    check("after_reset_const", ReadData[95:64], 32'h0);
    idle_inputs();
    InitReq = 1'b1; InitData = 32'h13579BDF;
    set_rd(0, 5'd0); set_rd(1, 5'd1);
    tick("restart");
    idle_inputs();
    tick("restart_w0");
    check("restart_w0_const", ReadData[31:0], 32'h13579BDF);
    check("restart_w1_const", ReadData[63:32], 32'h0);
    repeat (NW) tick("restart_sweep");
    for (int w = 0; w < NW; w++) begin
      set_rd(2, AW'(w));
      tick("restart_readback");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
